servo_ramp: RTL and testbench

Slew-rate limiter that sits directly upstream of the hobby-servo PWM generator. It accepts per-servo target positions over a valid/ready write port and drives the flattened position array. Each frame it moves every servo's current position toward its target by at most STEP counts, so commanded jumps become bounded-rate motion. Frame length matches the PWM generator's 2^20-cycle period at 50 MHz (~20.97 ms).

---
 rtl/servo_ramp.sv | 113 +++++++++++
 tb/tb_servo_ramp.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/servo_ramp.sv
`timescale 1ns/1ps
// Slew-rate limiter between target writes and the servo PWM block.
// Once per frame it sweeps every servo and moves cur toward target by at most STEP.
//
// state  | meaning
// IDLE   | counting out the frame; target writes accepted
// UPDATE | sweeping servo idx, one per cycle; writes stalled
module servo_ramp #(
    parameter int WIDTH      = 16,
    parameter int NUM        = 1,
    parameter int ADDR_W     = 4,
    parameter int STEP       = 256,
    parameter int FRAME_BITS = 20
) (
    input  logic                   clk50Mhz,
    input  logic                   rst,
    input  logic                   wrValid,
    output logic                   wrReady,
    input  logic [ADDR_W-1:0]      wrAddr,
    input  logic [WIDTH-1:0]       wrData,
    output logic [WIDTH*NUM-1:0]   posArray,
    output logic                   busy,
    output logic                   badAddr,
    output logic                   frameTick
);

    if (WIDTH < 2 || WIDTH > 16 || NUM < 1 || NUM > (1 << ADDR_W) || STEP < 1 ||
        FRAME_BITS <= ADDR_W) begin : g_param_check
        $error("servo_ramp: illegal parameter combination");
    end

    typedef enum logic {IDLE, UPDATE} state_t;

    localparam logic [WIDTH-1:0]      MID      = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0]      STEP_W   = WIDTH'(STEP);
    localparam logic [FRAME_BITS-1:0] CNT_PRE  = {{(FRAME_BITS-1){1'b1}}, 1'b0};
    localparam logic [ADDR_W-1:0]     IDX_LAST = ADDR_W'(NUM - 1);
    localparam logic [ADDR_W:0]       NUM_A    = (ADDR_W + 1)'(NUM);

    state_t                  state;
    logic [ADDR_W-1:0]       idx;
    logic [FRAME_BITS-1:0]   cnt;
    logic [WIDTH-1:0]        target [NUM];
    logic [WIDTH-1:0]        cur    [NUM];
    logic                    wr_fire;

    // The diff is one bit wider than a position, so the comparison never wraps;
    // a STEP at or above 2^WIDTH can never be exceeded and cur lands on target.
    function automatic logic [WIDTH-1:0] step_toward(input logic [WIDTH-1:0] tgt,
                                                     input logic [WIDTH-1:0] c);
        logic signed [WIDTH:0] diff;
        int                    d;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, c});
        d    = int'(diff);
        if (d > STEP)
            return c + STEP_W;
        else if (d < -STEP)
            return c - STEP_W;
        else
            return tgt;
    endfunction

    assign wrReady = (state == IDLE);
    assign busy    = (state == UPDATE);
    assign wr_fire = wrValid && wrReady;

    always_ff @(posedge clk50Mhz) begin
        if (rst) begin
            cnt       <= '0;
            frameTick <= 1'b0;
            state     <= IDLE;
            idx       <= '0;
            badAddr   <= 1'b0;
            for (int i = 0; i < NUM; i++) begin
                target[i] <= MID;
                cur[i]    <= MID;
            end
        end else begin
            cnt       <= cnt + 1'b1;
            frameTick <= (cnt == CNT_PRE);
            badAddr   <= wr_fire && ({1'b0, wrAddr} >= NUM_A);

            for (int i = 0; i < NUM; i++) begin
                if (wr_fire && wrAddr == ADDR_W'(i))
                    target[i] <= wrData;
            end

            case (state)
                IDLE: begin
                    if (frameTick) begin
                        state <= UPDATE;
                        idx   <= '0;
                    end
                end
                UPDATE: begin
                    for (int i = 0; i < NUM; i++) begin
                        if (idx == ADDR_W'(i))
                            cur[i] <= step_toward(target[i], cur[i]);
                    end
                    idx <= idx + 1'b1;
                    if (idx == IDX_LAST)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM; g++) begin : g_pos
        assign posArray[WIDTH*g +: WIDTH] = cur[g];
    end

endmodule

// File: tb/tb_servo_ramp.sv
`timescale 1ns/1ps
// Bench for servo_ramp: a 2-servo instance checked per frame through a scoreboard,
// and a 4-servo instance used for the mid-sweep reset case.
module tb_servo_ramp;

    logic        clk50Mhz = 1'b0;
    always #10 clk50Mhz = ~clk50Mhz;

    logic        rst, wrValid, wrReady, busy, badAddr, frameTick;
    logic [3:0]  wrAddr;
    logic [15:0] wrData;
    logic [31:0] posArray;

    logic        rst4, wrValid4, wrReady4, busy4, badAddr4, frameTick4;
    logic [3:0]  wrAddr4;
    logic [15:0] wrData4;
    logic [63:0] pos4;

    servo_ramp #(.WIDTH(16), .NUM(2), .ADDR_W(4), .STEP(256), .FRAME_BITS(6)) dut (
        .clk50Mhz(clk50Mhz), .rst(rst), .wrValid(wrValid), .wrReady(wrReady),
        .wrAddr(wrAddr), .wrData(wrData), .posArray(posArray), .busy(busy),
        .badAddr(badAddr), .frameTick(frameTick));

    servo_ramp #(.WIDTH(16), .NUM(4), .ADDR_W(4), .STEP(256), .FRAME_BITS(6)) dut4 (
        .clk50Mhz(clk50Mhz), .rst(rst4), .wrValid(wrValid4), .wrReady(wrReady4),
        .wrAddr(wrAddr4), .wrData(wrData4), .posArray(pos4), .busy(busy4),
        .badAddr(badAddr4), .frameTick(frameTick4));

    int          nchk = 0;
    int          nerr = 0;
    logic [31:0] expq[$];
    bit          mon_en = 1'b0;
    logic        prev_busy = 1'b0;
    int          acc_cnt = 0;
    int          bad_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every completed sweep must match the next queued frame.
    always @(negedge clk50Mhz) begin
        if (mon_en && prev_busy && !busy) begin
            if (expq.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL unexpected sweep: posArray %h with no expected frame queued", posArray);
            end else begin
                check("frame posArray", 64'(posArray), 64'(expq.pop_front()));
            end
        end
        prev_busy <= busy;
        if (badAddr) bad_cnt <= bad_cnt + 1;
    end

    always @(posedge clk50Mhz) begin
        if (wrValid && wrReady) acc_cnt <= acc_cnt + 1;
    end

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk50Mhz);
            n++;
        end while (!frameTick && n < 200);
        if (!frameTick) begin
            nchk++;
            nerr++;
            $display("FAIL tick timeout: no frameTick within %0d cycles", n);
        end
    endtask

    task automatic frame(input logic [31:0] e, output int n);
        wait_tick(n);
        expq.push_back(e);
    endtask

    task automatic do_write(input logic [3:0] a, input logic [15:0] d);
        int n;
        @(negedge clk50Mhz);
        wrValid = 1'b1;
        wrAddr  = a;
        wrData  = d;
        n = 0;
        while (!wrReady && n < 100) begin
            @(negedge clk50Mhz);
            n++;
        end
        @(posedge clk50Mhz);
        #1 wrValid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, lowcnt, acc_before;
        rst = 1'b1; wrValid = 1'b0; wrAddr = '0; wrData = '0;
        rst4 = 1'b1; wrValid4 = 1'b0; wrAddr4 = '0; wrData4 = '0;
        repeat (3) @(posedge clk50Mhz);
        @(negedge clk50Mhz);
        check("reset posArray", 64'(posArray), 64'h8000_8000);
        check("reset wrReady", 64'(wrReady), 64'd1);
        check("reset busy", 64'(busy), 64'd0);
        check("reset badAddr", 64'(badAddr), 64'd0);
        check("reset frameTick", 64'(frameTick), 64'd0);
        check("reset badAddr4", 64'(badAddr4), 64'd0);
        rst = 1'b0;
        mon_en = 1'b1;

        // Ramp servo 0 up and servo 1 down (partial final step of 0x80).
        do_write(4'd0, 16'h8300);
        do_write(4'd1, 16'h7E80);
        frame(32'h7F00_8100, n);
        frame(32'h7E80_8200, n);
        frame(32'h7E80_8300, n);
        check("frame period", 64'(n), 64'd64);
        frame(32'h7E80_8300, n);

        // Out-of-range address: pulse one cycle, nothing moves.
        do_write(4'd3, 16'h1234);
        @(negedge clk50Mhz);
        check("badAddr pulse", 64'(badAddr), 64'd1);
        @(negedge clk50Mhz);
        check("badAddr width", 64'(badAddr), 64'd0);
        frame(32'h7E80_8300, n);
        frame(32'h7E80_8300, n);
        frame(32'h7E80_8300, n);

        // Write held across a tick stalls for the NUM-cycle sweep.
        wait_tick(n);
        expq.push_back(32'h7E80_8300);
        @(negedge clk50Mhz);
        acc_before = acc_cnt;
        wrValid = 1'b1; wrAddr = 4'd0; wrData = 16'h9000;
        lowcnt = 0;
        while (!wrReady && lowcnt < 100) begin
            lowcnt++;
            @(negedge clk50Mhz);
        end
        check("stall length", 64'(lowcnt), 64'd2);
        @(posedge clk50Mhz);
        #1 wrValid = 1'b0;
        @(negedge clk50Mhz);
        check("stall accepts once", 64'(acc_cnt - acc_before), 64'd1);
        frame(32'h7E80_8400, n);
        frame(32'h7E80_8500, n);

        // Write accepted on the tick cycle feeds the sweep that follows.
        wait_tick(n);
        expq.push_back(32'h7E00_8600);
        wrValid = 1'b1; wrAddr = 4'd1; wrData = 16'h7E00;
        @(posedge clk50Mhz);
        #1 wrValid = 1'b0;

        n = 0;
        while (expq.size() != 0 && n < 200) begin
            @(negedge clk50Mhz);
            n++;
        end
        check("scoreboard drained", 64'(expq.size()), 64'd0);
        mon_en = 1'b0;
        check("accepted writes", 64'(acc_cnt), 64'd5);
        check("badAddr pulses", 64'(bad_cnt), 64'd1);

        // Four-servo instance: reset on the second sweep cycle.
        @(negedge clk50Mhz);
        rst4 = 1'b0;
        wrValid4 = 1'b1; wrAddr4 = 4'd2; wrData4 = 16'h9000;
        n = 0;
        do begin
            @(negedge clk50Mhz);
            if (n == 0) wrValid4 = 1'b0;
            n++;
        end while (!frameTick4 && n < 200);
        check("first tick after reset", 64'(n), 64'd63);
        repeat (6) @(negedge clk50Mhz);
        check("num4 frame1 pos", pos4, 64'h8000_8100_8000_8000);
        n = 0;
        do begin
            @(negedge clk50Mhz);
            n++;
        end while (!frameTick4 && n < 200);
        check("num4 second tick", 64'(n), 64'd58);
        @(negedge clk50Mhz);
        check("num4 sweep started", 64'(busy4), 64'd1);
        @(negedge clk50Mhz);
        rst4 = 1'b1;
        @(negedge clk50Mhz);
        check("mid-sweep reset pos", pos4, 64'h8000_8000_8000_8000);
        check("mid-sweep reset busy", 64'(busy4), 64'd0);
        check("mid-sweep reset wrReady", 64'(wrReady4), 64'd1);
        rst4 = 1'b0;
        n = 0;
        do begin
            @(negedge clk50Mhz);
            n++;
        end while (!frameTick4 && n < 200);
        check("tick after mid-sweep reset", 64'(n), 64'd63);
        repeat (6) @(negedge clk50Mhz);
        check("targets reset", pos4, 64'h8000_8000_8000_8000);

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end

endmodule
